// File: rtl/ir_packet_receiver.sv
// IR packet receiver: recovers the carrier envelope from a raw IR input, measures burst and gap
// lengths in prescaled ticks, and decodes a start burst plus four data bursts into a command.
module ir_packet_receiver #(
    parameter int unsigned CLK_DIV     = 50,
    parameter int unsigned ENV_TIMEOUT = 2000,
    parameter int unsigned START_MIN   = 2000,
    parameter int unsigned START_MAX   = 2800,
    parameter int unsigned ONE_MIN     = 1000,
    parameter int unsigned ONE_MAX     = 1400,
    parameter int unsigned ZERO_MIN    = 450,
    parameter int unsigned ZERO_MAX    = 750,
    parameter int unsigned GAP_MAX     = 1500
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    output logic [3:0] COMMAND,
    output logic       VALID,
    output logic       ERROR,
    output logic       BUSY
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TW = $clog2(ENV_TIMEOUT + 1);

    localparam logic [PW-1:0] PrescLast = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TmoLast   = TW'(ENV_TIMEOUT - 1);
    localparam logic [15:0]   StartMin  = 16'(START_MIN);
    localparam logic [15:0]   StartMax  = 16'(START_MAX);
    localparam logic [15:0]   OneMin    = 16'(ONE_MIN);
    localparam logic [15:0]   OneMax    = 16'(ONE_MAX);
    localparam logic [15:0]   ZeroMin   = 16'(ZERO_MIN);
    localparam logic [15:0]   ZeroMax   = 16'(ZERO_MAX);
    localparam logic [15:0]   GapMax    = 16'(GAP_MAX);
    localparam logic [15:0]   CntSat    = 16'hFFFF;

    typedef enum logic [1:0] {StIdle, StData, StDone} state_e;

    // [0]/[1] form the synchroniser, [2] holds the previous synchronised value
    logic [2:0]    sync_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          env_q, env_d;
    logic [15:0]   burst_q, burst_d;
    logic [15:0]   last_q, last_d;
    logic [15:0]   gap_q, gap_d;
    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    shift_q, shift_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic        ir_edge;
    logic        tick;
    logic        env_rise;
    logic        env_fall;
    logic [15:0] burst_inc;
    logic        is_start;
    logic        is_one;
    logic        is_zero;

    assign ir_edge = sync_q[1] ^ sync_q[2];
    assign tick    = (presc_q == PrescLast);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        env_d    = env_q;
        tmo_d    = tmo_q;
        env_rise = 1'b0;
        env_fall = 1'b0;
        if (ir_edge) begin
            tmo_d = '0;
            if (!env_q) begin
                env_d    = 1'b1;
                env_rise = 1'b1;
            end
        end else if (env_q) begin
            if (tmo_q == TmoLast) begin
                env_d    = 1'b0;
                env_fall = 1'b1;
                tmo_d    = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // last_edge captures the count including this cycle's tick, so L spans first..last edge
    assign burst_inc = (tick && burst_q != CntSat) ? burst_q + 16'd1 : burst_q;

    always_comb begin
        burst_d = burst_q;
        last_d  = last_q;
        gap_d   = gap_q;
        if (env_rise) begin
            burst_d = '0;
        end else if (env_q) begin
            burst_d = burst_inc;
        end
        if (ir_edge) begin
            last_d = env_q ? burst_inc : 16'd0;
        end
        if (env_fall) begin
            gap_d = '0;
        end else if (!env_q && tick && gap_q != CntSat) begin
            gap_d = gap_q + 16'd1;
        end
    end

    assign is_start = (last_q >= StartMin) && (last_q <= StartMax);
    assign is_one   = (last_q >= OneMin) && (last_q <= OneMax);
    assign is_zero  = (last_q >= ZeroMin) && (last_q <= ZeroMax);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cmd_d   = cmd_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (env_fall && is_start) begin
                    state_d = StData;
                    idx_d   = 2'd0;
                end
            end
            StData: begin
                if (env_fall) begin
                    if (is_one || is_zero) begin
                        shift_d = {shift_q[2:0], is_one};
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = StDone;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end else if (!env_q && gap_q > GapMax) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                cmd_d   = shift_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q  <= '0;
            presc_q <= '0;
            tmo_q   <= '0;
            env_q   <= 1'b0;
            burst_q <= '0;
            last_q  <= '0;
            gap_q   <= '0;
            state_q <= StIdle;
            idx_q   <= '0;
            shift_q <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], IR_IN};
            presc_q <= presc_d;
            tmo_q   <= tmo_d;
            env_q   <= env_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign COMMAND = cmd_q;
    assign VALID   = valid_q;
    assign ERROR   = error_q;
    assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_ir_packet_receiver.sv
// Bench for ir_packet_receiver: a scaled instance for packet scenarios and randomized sequences,
// and a one-cycle-tick instance for exact window and timeout boundaries.
module tb_ir_packet_receiver;

    localparam int D1 = 4, T1 = 12, SMIN1 = 200, SMAX1 = 280, OMIN1 = 100, OMAX1 = 140;
    localparam int ZMIN1 = 45, ZMAX1 = 75, G1 = 150, H1 = 3;
    localparam int D2 = 1, T2 = 8, SMIN2 = 40, SMAX2 = 50, OMIN2 = 20, OMAX2 = 24;
    localparam int ZMIN2 = 10, ZMAX2 = 14, G2 = 30, H2 = 2;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, rst2 = 1'b1, ir1 = 1'b0, ir2 = 1'b0;
    logic [3:0] cmd1, cmd2;
    logic       v1, e1, b1, v2, e2, b2;

    always #5 clk = ~clk;

    ir_packet_receiver #(
        .CLK_DIV(D1), .ENV_TIMEOUT(T1), .START_MIN(SMIN1), .START_MAX(SMAX1), .ONE_MIN(OMIN1),
        .ONE_MAX(OMAX1), .ZERO_MIN(ZMIN1), .ZERO_MAX(ZMAX1), .GAP_MAX(G1)
    ) u_dut1 (
        .CLK(clk), .RESET(rst1), .IR_IN(ir1), .COMMAND(cmd1), .VALID(v1), .ERROR(e1), .BUSY(b1)
    );

    ir_packet_receiver #(
        .CLK_DIV(D2), .ENV_TIMEOUT(T2), .START_MIN(SMIN2), .START_MAX(SMAX2), .ONE_MIN(OMIN2),
        .ONE_MAX(OMAX2), .ZERO_MIN(ZMIN2), .ZERO_MAX(ZMAX2), .GAP_MAX(G2)
    ) u_dut2 (
        .CLK(clk), .RESET(rst2), .IR_IN(ir2), .COMMAND(cmd2), .VALID(v2), .ERROR(e2), .BUSY(b2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0, tests_failed = 0;
    int tog1 = 0, tog2 = 0;
    int vcnt1 = 0, ecnt1 = 0, vcyc1 = 0, ecyc1 = 0, bcnt1 = 0, proto1 = 0;
    int vcnt2 = 0, ecnt2 = 0, vcyc2 = 0, ecyc2 = 0, proto2 = 0;
    logic pv1 = 1'b0, pe1 = 1'b0, pv2 = 1'b0, pe2 = 1'b0;
    logic [3:0] exp_cmd1 = 4'd0;
    int bl_q[$];
    int gp_q[$];

    always @(negedge clk) begin
        if (v1 === 1'b1) begin vcnt1 <= vcnt1 + 1; vcyc1 <= cyc; end
        if (e1 === 1'b1) begin ecnt1 <= ecnt1 + 1; ecyc1 <= cyc; end
        if (b1 === 1'b1) bcnt1 <= bcnt1 + 1;
        if ((v1 && e1) || (v1 && pv1) || (e1 && pe1)) proto1 <= proto1 + 1;
        pv1 <= v1;
        pe1 <= e1;
        if (v2 === 1'b1) begin vcnt2 <= vcnt2 + 1; vcyc2 <= cyc; end
        if (e2 === 1'b1) begin ecnt2 <= ecnt2 + 1; ecyc2 <= cyc; end
        if ((v2 && e2) || (v2 && pv2) || (e2 && pe2)) proto2 <= proto2 + 1;
        pv2 <= v2;
        pe2 <= e2;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle(input int sel);
        if (sel == 1) begin ir1 = ~ir1; tog1 = cyc; end
        else begin ir2 = ~ir2; tog2 = cyc; end
    endtask

    // Carrier burst whose first and last input changes are len_cyc cycles apart
    task automatic burst(input int sel, input int len_cyc, input int first_step);
        int t, step;
        toggle(sel);
        t = 0;
        while (t < len_cyc) begin
            step = (sel == 1) ? H1 : H2;
            if (t == 0 && first_step > 0) step = first_step;
            if (step > len_cyc - t) step = len_cyc - t;
            wait_cyc(step);
            t += step;
            toggle(sel);
        end
    endtask

    task automatic clr();
        bl_q.delete();
        gp_q.delete();
    endtask

    task automatic add(input int len, input int gap);
        bl_q.push_back(len);
        gp_q.push_back(gap);
    endtask

    task automatic send(input int sel);
        int d;
        d = (sel == 1) ? D1 : D2;
        for (int i = 0; i < bl_q.size(); i++) begin
            burst(sel, bl_q[i] * d, 0);
            wait_cyc(gp_q[i] * d);
        end
    endtask

    // Packet-level reference: lengths and gaps in ticks, classified against the windows
    task automatic model_seq(input logic [3:0] cmd_in, output int nv, output int ne,
                             output logic [3:0] cmd_out);
        bit in_pkt;
        int nbits, val, len;
        bit s, o, z;
        nv = 0; ne = 0; cmd_out = cmd_in; in_pkt = 0; nbits = 0; val = 0;
        for (int i = 0; i < bl_q.size(); i++) begin
            len = bl_q[i];
            s = (len >= SMIN1 && len <= SMAX1);
            o = (len >= OMIN1 && len <= OMAX1);
            z = (len >= ZMIN1 && len <= ZMAX1);
            if (!in_pkt) begin
                if (s) begin in_pkt = 1; nbits = 0; val = 0; end
            end else if (o || z) begin
                val = val * 2 + (o ? 1 : 0);
                nbits++;
                if (nbits == 4) begin nv++; cmd_out = 4'(val); in_pkt = 0; end
            end else begin
                ne++; in_pkt = 0;
            end
            if (in_pkt && gp_q[i] > G1) begin ne++; in_pkt = 0; end
        end
    endtask

    task automatic test_reset();
        wait_cyc(3);
        tests_run++;
        if ({cmd1, v1, e1, b1} !== 7'd0) begin
            tests_failed++; $display("FAIL reset_dut1: got %b want 0000000", {cmd1, v1, e1, b1});
        end
        tests_run++;
        if ({cmd2, v2, e2, b2} !== 7'd0) begin
            tests_failed++; $display("FAIL reset_dut2: got %b want 0000000", {cmd2, v2, e2, b2});
        end
        rst1 = 1'b0;
        rst2 = 1'b0;
        wait_cyc(5);
        tests_run++;
        if ({cmd1, v1, e1, b1} !== 7'd0) begin
            tests_failed++; $display("FAIL post_reset: got %b want 0000000", {cmd1, v1, e1, b1});
        end
    endtask

    task automatic test_valid_packet();
        int bv, be, bb, t_last;
        bv = vcnt1; be = ecnt1; bb = bcnt1;
        clr();
        add(240, 60); add(120, 60); add(60, 60); add(120, 60); add(60, 0);
        send(1);
        t_last = tog1;
        wait_cyc(60 * D1);
        exp_cmd1 = 4'b1010;
        tests_run++;
        if (vcnt1 - bv !== 1) begin
            tests_failed++; $display("FAIL valid_count: got %0d want 1", vcnt1 - bv);
        end
        tests_run++;
        if (cmd1 !== exp_cmd1) begin
            tests_failed++; $display("FAIL valid_cmd: got %b want %b", cmd1, exp_cmd1);
        end
        tests_run++;
        if (vcyc1 - t_last !== T1 + 4) begin
            tests_failed++; $display("FAIL valid_latency: got %0d want %0d", vcyc1 - t_last, T1 + 4);
        end
        tests_run++;
        if (ecnt1 - be !== 0) begin
            tests_failed++; $display("FAIL valid_no_error: got %0d want 0", ecnt1 - be);
        end
        tests_run++;
        if (bcnt1 - bb == 0) begin
            tests_failed++; $display("FAIL valid_busy: got 0 busy cycles want nonzero");
        end
    endtask

    task automatic test_short_start();
        int bv, be, bb;
        bv = vcnt1; be = ecnt1; bb = bcnt1;
        clr();
        add(150, 60); add(120, 60); add(60, 60); add(120, 60); add(60, 60);
        send(1);
        tests_run++;
        if (vcnt1 - bv !== 0 || ecnt1 - be !== 0) begin
            tests_failed++;
            $display("FAIL short_start_strobes: got v=%0d e=%0d want 0 0", vcnt1 - bv, ecnt1 - be);
        end
        tests_run++;
        if (bcnt1 - bb !== 0) begin
            tests_failed++; $display("FAIL short_start_busy: got %0d want 0", bcnt1 - bb);
        end
        tests_run++;
        if (cmd1 !== exp_cmd1) begin
            tests_failed++; $display("FAIL short_start_cmd: got %b want %b", cmd1, exp_cmd1);
        end
    endtask

    task automatic test_gap_timeout();
        int bv, be, t_last, lo, hi;
        bv = vcnt1; be = ecnt1;
        clr();
        add(240, 60); add(120, 60); add(60, 200);
        send(1);
        t_last = tog1;
        lo = T1 + G1 * D1 + 5;
        hi = T1 + G1 * D1 + D1 + 4;
        tests_run++;
        if (ecnt1 - be !== 1) begin
            tests_failed++; $display("FAIL gap_err_count: got %0d want 1", ecnt1 - be);
        end
        tests_run++;
        if (ecyc1 - t_last < lo || ecyc1 - t_last > hi) begin
            tests_failed++;
            $display("FAIL gap_err_time: got %0d want %0d..%0d", ecyc1 - t_last, lo, hi);
        end
        tests_run++;
        if (b1 !== 1'b0) begin
            tests_failed++; $display("FAIL gap_idle: got busy=%b want 0", b1);
        end
        clr();
        add(240, 60); add(60, 60); add(120, 60); add(60, 60); add(120, 60);
        send(1);
        exp_cmd1 = 4'b0101;
        tests_run++;
        if (vcnt1 - bv !== 1 || cmd1 !== exp_cmd1) begin
            tests_failed++;
            $display("FAIL gap_next_pkt: got v=%0d cmd=%b want 1 %b", vcnt1 - bv, cmd1, exp_cmd1);
        end
    endtask

    task automatic test_invalid_data();
        int bv, be, t_last;
        bv = vcnt1; be = ecnt1;
        clr();
        add(240, 60); add(90, 0);
        send(1);
        t_last = tog1;
        wait_cyc(60 * D1);
        tests_run++;
        if (ecnt1 - be !== 1 || vcnt1 - bv !== 0) begin
            tests_failed++;
            $display("FAIL invalid_strobes: got e=%0d v=%0d want 1 0", ecnt1 - be, vcnt1 - bv);
        end
        tests_run++;
        if (ecyc1 - t_last !== T1 + 3) begin
            tests_failed++; $display("FAIL invalid_latency: got %0d want %0d", ecyc1 - t_last, T1 + 3);
        end
    endtask

    task automatic test_reset_mid_packet();
        int bv, be;
        bv = vcnt1; be = ecnt1;
        clr();
        add(240, 60); add(120, 60); add(60, 60);
        send(1);
        burst(1, 40 * D1, 0);
        rst1 = 1'b1;
        wait_cyc(1);
        rst1 = 1'b0;
        tests_run++;
        if ({cmd1, v1, e1, b1} !== 7'd0) begin
            tests_failed++; $display("FAIL midreset_outputs: got %b want 0000000", {cmd1, v1, e1, b1});
        end
        exp_cmd1 = 4'b0000;
        burst(1, 80 * D1, 0);
        wait_cyc(60 * D1);
        burst(1, 120 * D1, 0);
        wait_cyc(200 * D1);
        tests_run++;
        if (vcnt1 - bv !== 0 || ecnt1 - be !== 0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got v=%0d e=%0d want 0 0", vcnt1 - bv, ecnt1 - be);
        end
        clr();
        add(240, 60); add(120, 60); add(60, 60); add(60, 60); add(120, 60);
        send(1);
        exp_cmd1 = 4'b1001;
        tests_run++;
        if (vcnt1 - bv !== 1 || cmd1 !== exp_cmd1) begin
            tests_failed++;
            $display("FAIL midreset_next: got v=%0d cmd=%b want 1 %b", vcnt1 - bv, cmd1, exp_cmd1);
        end
    endtask

    function automatic int rand_len(input int cat);
        int k;
        case (cat)
            0: return 210 + int'($urandom_range(0, 60));
            1: return 105 + int'($urandom_range(0, 30));
            2: return 50 + int'($urandom_range(0, 20));
            default: begin
                k = int'($urandom_range(0, 2));
                if (k == 0) return 80 + int'($urandom_range(0, 15));
                if (k == 1) return 150 + int'($urandom_range(0, 40));
                return 290 + int'($urandom_range(0, 30));
            end
        endcase
    endfunction

    task automatic test_random();
        int bv, be, nv, ne, r, cat, gap;
        logic [3:0] mcmd;
        for (int round = 0; round < 3; round++) begin
            bv = vcnt1; be = ecnt1;
            clr();
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 9));
                cat = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
                if (i == 7) gap = 200;
                else if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(170, 200));
                else gap = int'($urandom_range(20, 130));
                add(rand_len(cat), gap);
            end
            model_seq(exp_cmd1, nv, ne, mcmd);
            send(1);
            exp_cmd1 = mcmd;
            tests_run++;
            if (vcnt1 - bv !== nv || ecnt1 - be !== ne) begin
                tests_failed++;
                $display("FAIL random_%0d_strobes: got v=%0d e=%0d want %0d %0d",
                         round, vcnt1 - bv, ecnt1 - be, nv, ne);
            end
            tests_run++;
            if (cmd1 !== exp_cmd1) begin
                tests_failed++; $display("FAIL random_%0d_cmd: got %b want %b", round, cmd1, exp_cmd1);
            end
        end
    endtask

    task automatic test_boundaries();
        int bv, be, t_last;
        bv = vcnt2; be = ecnt2;
        clr();
        add(45, 15); add(OMIN2, 15); add(OMAX2, 15); add(ZMIN2, 15); add(ZMAX2, 0);
        send(2);
        t_last = tog2;
        wait_cyc(40);
        tests_run++;
        if (vcnt2 - bv !== 1 || ecnt2 - be !== 0 || cmd2 !== 4'b1100) begin
            tests_failed++;
            $display("FAIL bound_accept: got v=%0d e=%0d cmd=%b want 1 0 1100",
                     vcnt2 - bv, ecnt2 - be, cmd2);
        end
        tests_run++;
        if (vcyc2 - t_last !== T2 + 4) begin
            tests_failed++; $display("FAIL bound_latency: got %0d want %0d", vcyc2 - t_last, T2 + 4);
        end
        bv = vcnt2; be = ecnt2;
        clr();
        add(SMIN2, 15); add(OMAX2 + 1, 0);
        send(2);
        t_last = tog2;
        wait_cyc(40);
        tests_run++;
        if (ecnt2 - be !== 1 || vcnt2 - bv !== 0) begin
            tests_failed++;
            $display("FAIL bound_one_max_plus1: got e=%0d v=%0d want 1 0", ecnt2 - be, vcnt2 - bv);
        end
        tests_run++;
        if (ecyc2 - t_last !== T2 + 3) begin
            tests_failed++; $display("FAIL bound_err_latency: got %0d want %0d", ecyc2 - t_last, T2 + 3);
        end
        be = ecnt2;
        clr();
        add(SMAX2, 15); add(ZMIN2 - 1, 40);
        send(2);
        tests_run++;
        if (ecnt2 - be !== 1 || vcnt2 - bv !== 0) begin
            tests_failed++;
            $display("FAIL bound_zero_min_minus1: got e=%0d v=%0d want 1 0", ecnt2 - be, vcnt2 - bv);
        end
        // First change of the next burst lands exactly on the timeout expiry cycle
        bv = vcnt2; be = ecnt2;
        burst(2, 45, 0);
        wait_cyc(15);
        burst(2, 22, T2);
        wait_cyc(15);
        clr();
        add(12, 15); add(21, 15); add(11, 40);
        send(2);
        tests_run++;
        if (vcnt2 - bv !== 1 || ecnt2 - be !== 0 || cmd2 !== 4'b1010) begin
            tests_failed++;
            $display("FAIL bound_edge_at_timeout: got v=%0d e=%0d cmd=%b want 1 0 1010",
                     vcnt2 - bv, ecnt2 - be, cmd2);
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (proto1 !== 0) begin
            tests_failed++; $display("FAIL strobe_rules_dut1: got %0d violations want 0", proto1);
        end
        tests_run++;
        if (proto2 !== 0) begin
            tests_failed++; $display("FAIL strobe_rules_dut2: got %0d violations want 0", proto2);
        end
    endtask

    initial begin
        test_reset();
        test_valid_packet();
        test_short_start();
        test_gap_timeout();
        test_invalid_data();
        test_reset_mid_packet();
        test_random();
        test_boundaries();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ir_packet_receiver.md
Name: ir_packet_receiver

Overview:
- Receive end of the IR remote link: takes the raw carrier-modulated IR signal produced by the transmitter's divided-clock carrier and recovers the burst envelope.
- Measures burst lengths in microsecond ticks and decodes a packet of one start burst followed by 4 data bursts into a 4-bit command.
- Sits between the board IR sensor pin and the command/control logic.
- Reports each decoded packet with a single-cycle VALID strobe. Malformed packets raise a single-cycle ERROR strobe.

Parameters:
- CLK_DIV, 50, CLK cycles per tick (1 µs at 50 MHz).
- ENV_TIMEOUT, 2000, CLK cycles without an input edge before the carrier is declared absent. Must exceed the carrier half-period.
- START_MIN, 2000, minimum start-burst length in ticks.
- START_MAX, 2800, maximum start-burst length in ticks.
- ONE_MIN, 1000, minimum length in ticks for a '1' data burst.
- ONE_MAX, 1400, maximum length in ticks for a '1' data burst.
- ZERO_MIN, 450, minimum length in ticks for a '0' data burst.
- ZERO_MAX, 750, maximum length in ticks for a '0' data burst.
- GAP_MAX, 1500, maximum inter-burst gap in ticks inside a packet.

Ports:
- CLK  input  1  master clock, 50 MHz.
- RESET  input  1  synchronous, active-high reset.
- IR_IN  input  1  raw asynchronous IR signal (carrier square wave during bursts, static during gaps).
- COMMAND  output  4  last successfully decoded command. First data burst maps to bit 3.
- VALID  output  1  one-cycle strobe: COMMAND has just been updated.
- ERROR  output  1  one-cycle strobe: packet aborted after a valid start burst.
- BUSY  output  1  high while the FSM is outside IDLE.

Behaviour:
- Reset: RESET is synchronous, active-high, and wins over all other activity, including mid-packet. It clears every register: FSM=IDLE, COMMAND=0, VALID=0, ERROR=0, BUSY=0, synchroniser=0, envelope=0, all counters=0.
- Input: IR_IN passes through a 2-flop synchroniser. An edge is any change of the synchronised value between consecutive cycles.
- Envelope:
  - env rises on the first edge while env=0.
  - Each edge reloads the timeout counter.
  - env falls in the cycle the timeout counter reaches ENV_TIMEOUT with no edge.
  - An edge in that same cycle wins, and env stays high.
- Tick: a free-running prescaler counts 0..CLK_DIV-1 and pulses tick for one cycle at CLK_DIV-1.
- Burst length:
  - The burst counter clears on env rise and increments on tick while env=1.
  - It saturates at 16'hFFFF; there is no wrap.
  - On every edge its value is latched into last_edge.
  - Burst length L = last_edge at env fall, i.e. ticks from first to last edge. The timeout tail is excluded.
- Gap: the gap counter clears on env fall, increments on tick while env=0, and saturates at 16'hFFFF.
- Classification uses inclusive windows: START when START_MIN<=L<=START_MAX; ONE and ZERO likewise with their MIN/MAX; anything else is invalid.
- FSM:
  - IDLE: on env fall, if L is START go to DATA with bit index=0; otherwise stay in IDLE with no ERROR.
  - DATA, env=0:
    - If gap > GAP_MAX, pulse ERROR and go to IDLE.
  - DATA, on env fall:
    - If L is ONE or ZERO, shift the bit into the shift register and increment the index.
    - If the burst is invalid, pulse ERROR and go to IDLE.
    - When the 4th bit is accepted, go to DONE.
  - DONE: lasts one cycle. COMMAND <= shift register, VALID=1, then go to IDLE.
- Latency: VALID is asserted 2 cycles after the env-fall cycle of the 4th data burst.
- VALID and ERROR are never high together and never high for more than one cycle.
- COMMAND holds its value across errors and between packets.
- BUSY=1 in DATA and DONE.
- A start-length burst arriving in DATA is treated as an invalid data burst: ERROR, then IDLE. It is not a resync.

Test Plan:
1. Valid packet: 36 kHz carrier bursts of 2400, 1200, 600, 1200, 600 µs with 600 µs gaps -> exactly one VALID, 2 cycles after the final env fall; COMMAND=4'b1010; ERROR never asserted.
2. Short start: 1500 µs start burst followed by 4 valid bursts -> no VALID, no ERROR; COMMAND unchanged; BUSY stays 0.
3. Gap timeout: valid start, then 2 data bursts, then 2000 µs of silence -> ERROR pulse at gap tick 1501; FSM back in IDLE; a following valid packet for 4'b0101 decodes correctly.
4. Invalid data burst: valid start, then a 900 µs burst -> ERROR one cycle after that burst's env fall; no VALID.
5. Reset mid-packet: assert RESET for 1 cycle during the 3rd data burst -> all outputs 0 next cycle; the remainder of that packet produces no VALID and no ERROR; the next full packet decodes.
6. Window boundaries, with CLK_DIV=1 and small windows: bursts of exactly ONE_MIN, ONE_MAX, ZERO_MIN and ZERO_MAX are accepted; ONE_MAX+1 and ZERO_MIN-1 give ERROR. An edge coincident with timeout expiry keeps env high.
